// File: rtl/mic_sample_sequencer.sv
// Paces MIC3 reader requests at the audio sample rate and converts offset-binary samples to two's complement.
// Samples are buffered in a FWFT FIFO. Define MIC_DC_REMOVE_EN to insert a DC-blocking stage before the FIFO.
module mic_sample_sequencer #(
  parameter int CLK_HZ      = 100000000,
  parameter int SAMPLE_HZ   = 48000,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic                          read,
  input  logic [11:0]                   audio_in,
  input  logic                          new_data_in,
  output logic [15:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    overrun_cnt,
  output logic [7:0]                    miss_cnt,
  output logic                          timeout_flag
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int OW  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [OW-1:0] TO_LAST  = OW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    REQ       = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  function automatic logic [15:0] to_twos(input logic [11:0] a);
    to_twos = {{4{~a[11]}}, ~a[11], a[10:0]};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) sat_inc8 = v;
    else            sat_inc8 = v + 8'd1;
  endfunction

  state_t          state_r, state_s;
  logic [TW-1:0]   tick_cnt_r;
  logic [OW-1:0]   to_cnt_r;
  logic            tick_s, miss_s, capture_s, timeout_s;
  logic            read_r, timeout_r;
  logic [7:0]      overrun_r, miss_r;
  logic [15:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            pop_s, push_s, drop_s;
  logic [15:0]     x_s, fifo_wdata_s;

  assign tick_s = enable && (tick_cnt_r == DIV_LAST);
  assign miss_s = tick_s && ((state_r == REQ) || (state_r == WAIT_DATA));
  assign x_s    = to_twos(audio_in);

`ifdef MIC_DC_REMOVE_EN
  function automatic logic [15:0] sat16(input logic [16:0] v);
    if (v[16] != v[15]) sat16 = v[16] ? 16'h8000 : 16'h7FFF;
    else                sat16 = v[15:0];
  endfunction

  logic signed [23:0] acc_r;
  logic        [15:0] avg_s;
  logic        [16:0] diff_s;

  // avg is acc>>>8 truncated to the 16-bit sample range
  assign avg_s        = acc_r[23:8];
  assign diff_s       = {x_s[15], x_s} - {avg_s[15], avg_s};
  assign fifo_wdata_s = sat16(diff_s);

  // DC estimate accumulator, updated on every captured sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 24'sd0;
    end else if (capture_s) begin
      acc_r <= acc_r + $signed({{7{diff_s[16]}}, diff_s});
    end else begin
      acc_r <= acc_r;
    end
  end
`else
  assign fifo_wdata_s = x_s;
`endif

  // Next-state logic; dropping enable forces IDLE from any state
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    if (!enable) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:      state_s = WAIT_TICK;
        WAIT_TICK: begin
          if (tick_s) state_s = REQ;
          else        state_s = WAIT_TICK;
        end
        REQ:       state_s = WAIT_DATA;
        WAIT_DATA: begin
          if (new_data_in) begin
            capture_s = 1'b1;
            state_s   = WAIT_TICK;
          end else if (to_cnt_r == TO_LAST) begin
            timeout_s = 1'b1;
            state_s   = WAIT_TICK;
          end else begin
            state_s   = WAIT_DATA;
          end
        end
        default:   state_s = IDLE;
      endcase
    end
  end

  // State register, registered read strobe and sample-rate tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      read_r     <= 1'b0;
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      state_r <= state_s;
      read_r  <= (state_s == REQ);
      if (!enable || tick_s) tick_cnt_r <= {TW{1'b0}};
      else                   tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Timeout counter is zero on entry to REQ and counts cycles since the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r  <= {OW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if ((state_r == REQ) || (state_r == WAIT_DATA)) to_cnt_r <= to_cnt_r + {{(OW-1){1'b0}}, 1'b1};
      else                                             to_cnt_r <= {OW{1'b0}};
      if (!enable)        timeout_r <= 1'b0;
      else if (timeout_s) timeout_r <= 1'b1;
      else                timeout_r <= timeout_r;
    end
  end

  assign pop_s  = (count_r != {CW{1'b0}}) && m_ready;
  assign push_s = capture_s && ((count_r != DEPTH_C) || pop_s);
  assign drop_s = capture_s && !push_s;

  // FIFO storage, pointers and occupancy; a full FIFO still accepts when popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 16'h0000;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= fifo_wdata_s;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      else       rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 8'd0;
      miss_r    <= 8'd0;
    end else begin
      if (drop_s) overrun_r <= sat_inc8(overrun_r);
      else        overrun_r <= overrun_r;
      if (miss_s) miss_r <= sat_inc8(miss_r);
      else        miss_r <= miss_r;
    end
  end

  assign read         = read_r;
  assign m_data       = mem_r[rd_ptr_r];
  assign m_valid      = (count_r != {CW{1'b0}});
  assign fifo_count   = count_r;
  assign overrun_cnt  = overrun_r;
  assign miss_cnt     = miss_r;
  assign timeout_flag = timeout_r;

endmodule

// File: tb/tb_mic_sample_sequencer.sv
// Directed bench for mic_sample_sequencer: conversion table, FIFO overrun/drain, timeout, missed ticks, reset.
// With MIC_DC_REMOVE_EN defined it runs the DC-blocking settle check instead of the conversion checks.
module tb_mic_sample_sequencer;
  localparam int CLK_HZ_TB = 100000000;
`ifdef MIC_DC_REMOVE_EN
  localparam int SAMPLE_HZ_TB = 3000000;
`else
  localparam int SAMPLE_HZ_TB = 1000000;
`endif
  localparam int DIV_TB   = CLK_HZ_TB / SAMPLE_HZ_TB;
  localparam int DEPTH_TB = 16;
  localparam int TO_TB    = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        new_data_in = 1'b0;
  logic        m_ready = 1'b0;
  logic [11:0] audio_in = 12'h000;
  logic        read, m_valid, timeout_flag;
  logic [15:0] m_data;
  logic [4:0]  fifo_count;
  logic [7:0]  overrun_cnt, miss_cnt;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;

  typedef struct {
    logic [11:0] audio;
    logic [15:0] data;
  } conv_vec_t;
  conv_vec_t conv_tab [7];

  mic_sample_sequencer #(
    .CLK_HZ(CLK_HZ_TB), .SAMPLE_HZ(SAMPLE_HZ_TB), .FIFO_DEPTH(DEPTH_TB), .TIMEOUT_CYC(TO_TB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read(read), .audio_in(audio_in),
    .new_data_in(new_data_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overrun_cnt(overrun_cnt), .miss_cnt(miss_cnt),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_read"}, {31'd0, read}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_data"}, {16'd0, m_data}, 32'd0);
    check({tag, "_fifo_count"}, {27'd0, fifo_count}, 32'd0);
    check({tag, "_overrun"}, {24'd0, overrun_cnt}, 32'd0);
    check({tag, "_miss"}, {24'd0, miss_cnt}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout_flag}, 32'd0);
  endtask

  task automatic wait_read(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (read === 1'b1) return;
    end
    vec_cnt++;
    err_cnt++;
    $display("FAIL read_wait: no read strobe within %0d cycles", budget);
  endtask

  // Called from the negedge of the read cycle; new_data_in is sampled delay+1 edges later.
  task automatic respond(input logic [11:0] a, input int delay);
    repeat (delay) @(negedge clk);
    audio_in    = a;
    new_data_in = 1'b1;
    @(negedge clk);
    new_data_in = 1'b0;
  endtask

  initial begin
    int c0, r0, bad;
    logic [15:0] y, prev;
    conv_tab[0] = '{12'hCDE, 16'h04DE};
    conv_tab[1] = '{12'h123, 16'hF923};
    conv_tab[2] = '{12'h800, 16'h0000};
    conv_tab[3] = '{12'hFFF, 16'h07FF};
    conv_tab[4] = '{12'h000, 16'hF800};
    conv_tab[5] = '{12'h7FF, 16'hFFFF};
    conv_tab[6] = '{12'h801, 16'h0001};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    wait_read(DIV_TB + 20);
    check("first_read_latency", cyc - c0, DIV_TB);

`ifdef MIC_DC_REMOVE_EN
    bad  = 0;
    prev = 16'h0000;
    y    = 16'h0000;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) wait_read(DIV_TB + 10);
      respond(12'h900, 2);
      y = m_data;
      if (i == 0) check("dc_first", {16'd0, y}, 32'h0100);
      else if (y > prev) bad++;
      prev = y;
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    check("dc_monotonic_violations", bad, 0);
    check("dc_settled", {31'd0, (y < 16'h0010)}, 32'd1);
`else
    // Conversion table: one sample per tick, popped right away.
    r0 = cyc;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        wait_read(DIV_TB + 10);
        check("read_period", cyc - r0, DIV_TB);
        r0 = cyc;
      end
      @(negedge clk);
      check("read_one_cycle", {31'd0, read}, 32'd0);
      respond(conv_tab[i].audio, 29);
      check("conv_valid", {31'd0, m_valid}, 32'd1);
      check("conv_data", {16'd0, m_data}, {16'd0, conv_tab[i].data});
      check("conv_count", {27'd0, fifo_count}, 32'd1);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("conv_pop_empty", {31'd0, m_valid}, 32'd0);
    end

    // Fill past full with the consumer stalled; the 17th sample is dropped.
    for (int i = 0; i <= DEPTH_TB; i++) begin
      wait_read(DIV_TB + 10);
      respond(12'h800 + 12'(i), 30);
    end
    check("full_count", {27'd0, fifo_count}, DEPTH_TB);
    check("full_overrun", {24'd0, overrun_cnt}, 32'd1);
    check("full_head_held", {16'd0, m_data}, 32'd0);
    check("no_miss_yet", {24'd0, miss_cnt}, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH_TB; i++) begin
      check("drain_valid", {31'd0, m_valid}, 32'd1);
      check("drain_data", {16'd0, m_data}, i);
      @(negedge clk);
    end
    check("drain_empty", {31'd0, m_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("ready_on_empty_count", {27'd0, fifo_count}, 32'd0);
    m_ready = 1'b0;

    // No reply: timeout, ticks during the wait are missed, next read on the next tick.
    wait_read(2 * DIV_TB);
    r0 = cyc;
    check("timeout_clear_before", {31'd0, timeout_flag}, 32'd0);
    for (int n = 0; n < TO_TB + 50; n++) begin
      if (timeout_flag === 1'b1) break;
      @(negedge clk);
    end
    check("timeout_latency", cyc - r0, TO_TB);
    wait_read(2 * DIV_TB);
    check("read_after_timeout", cyc - r0, (TO_TB / DIV_TB + 1) * DIV_TB);
    check("miss_after_timeout", {24'd0, miss_cnt}, TO_TB / DIV_TB);

    // Reply 150 cycles late: one missed tick, read resumes on the following tick.
    r0 = cyc;
    respond(12'h800, 150);
    wait_read(2 * DIV_TB);
    check("read_after_late_reply", cyc - r0, 2 * DIV_TB);
    check("miss_after_late_reply", {24'd0, miss_cnt}, TO_TB / DIV_TB + 1);
    check("timeout_sticky", {31'd0, timeout_flag}, 32'd1);
    check("late_reply_stored", {27'd0, fifo_count}, 32'd1);

    // Disable: flag clears, FIFO and counters kept.
    enable = 1'b0;
    @(negedge clk);
    check("disable_timeout_clr", {31'd0, timeout_flag}, 32'd0);
    check("disable_count_kept", {27'd0, fifo_count}, 32'd1);
    check("disable_miss_kept", {24'd0, miss_cnt}, TO_TB / DIV_TB + 1);
    check("disable_overrun_kept", {24'd0, overrun_cnt}, 32'd1);

    // Asynchronous reset in WAIT_DATA, then a stray new_data_in with enable low.
    enable = 1'b1;
    wait_read(DIV_TB + 20);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    respond(12'hCDE, 0);
    @(negedge clk);
    check_reset("post_reset_stray");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
